// File: rtl/time_set_editor.sv
// Wall-clock timekeeper (BCD hh:mm:ss) with a button-driven field editor.
// currentState doubles as the edit FSM state; activeBlink holds the edited field steady.
module time_set_editor #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned EDIT_TIMEOUT  = 500_000_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic [1:0] currentState,
    output logic       activeBlink
);

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_SET_HOURS   = 2'd1,
        ST_SET_MINUTES = 2'd2,
        ST_SET_SECONDS = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_hours, r_minutes, r_seconds;
    logic        r_blink;
    logic [31:0] r_presc, r_rep, r_hold, r_tmo;
    logic        r_rep_fast;
    logic        r_mode_prev, r_up_prev, r_down_prev;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
        logic [3:0] hi;
        hi = v[7:4] + 4'd1;
        if (v == vmax)          return 8'h00;
        else if (v[3:0] == 4'd9) return {hi, 4'h0};
        else                     return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
        logic [3:0] hi;
        hi = v[7:4] - 4'd1;
        if (v == 8'h00)          return vmax;
        else if (v[3:0] == 4'd0) return {hi, 4'h9};
        else                     return v - 8'd1;
    endfunction

    logic   w_mode_press, w_up_press, w_down_press;
    logic   w_any_btn, w_one_btn, w_in_set;
    logic   w_tick, w_timeout, w_rep_due, w_press_step, w_step;
    state_t w_next_state;

    assign w_mode_press = btn_mode & ~r_mode_prev;
    assign w_up_press   = btn_up & ~r_up_prev;
    assign w_down_press = btn_down & ~r_down_prev;
    assign w_any_btn    = btn_mode | btn_up | btn_down;
    assign w_one_btn    = btn_up ^ btn_down;
    assign w_in_set     = (r_state != ST_RUN);

    assign w_tick    = !w_in_set && (r_presc == CLK_HZ - 1);
    assign w_timeout = w_in_set && !w_any_btn && (r_tmo == EDIT_TIMEOUT - 1);

    // r_rep == 0 means no repeat armed; only a fresh press arms it.
    assign w_rep_due    = (r_rep != 32'd0) &&
                          (r_rep_fast ? (r_rep == REPEAT_PERIOD) : (r_rep == REPEAT_DELAY));
    assign w_press_step = w_one_btn && (btn_up ? w_up_press : w_down_press);
    assign w_step       = w_in_set && !w_mode_press && w_one_btn && (w_press_step || w_rep_due);

    always_comb begin
        w_next_state = r_state;
        if (w_mode_press)   w_next_state = state_t'(r_state + 2'd1);
        else if (w_timeout) w_next_state = ST_RUN;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_RUN;
            r_hours     <= 8'h00;
            r_minutes   <= 8'h00;
            r_seconds   <= 8'h00;
            r_blink     <= 1'b0;
            r_presc     <= 32'd0;
            r_rep       <= 32'd0;
            r_rep_fast  <= 1'b0;
            r_hold      <= 32'd0;
            r_tmo       <= 32'd0;
            r_mode_prev <= 1'b0;
            r_up_prev   <= 1'b0;
            r_down_prev <= 1'b0;
        end else begin
            r_mode_prev <= btn_mode;
            r_up_prev   <= btn_up;
            r_down_prev <= btn_down;
            r_state     <= w_next_state;

            // Tick is applied before any mode change that leaves RUN this cycle.
            if (w_tick) begin
                r_presc <= 32'd0;
                if (r_seconds == 8'h59) begin
                    r_seconds <= 8'h00;
                    if (r_minutes == 8'h59) begin
                        r_minutes <= 8'h00;
                        r_hours   <= bcd_inc(r_hours, 8'h23);
                    end else begin
                        r_minutes <= bcd_inc(r_minutes, 8'h59);
                    end
                end else begin
                    r_seconds <= bcd_inc(r_seconds, 8'h59);
                end
            end else if (!w_in_set) begin
                r_presc <= r_presc + 32'd1;
            end else begin
                r_presc <= 32'd0;
            end

            if (w_step) begin
                case (r_state)
                    ST_SET_HOURS:   r_hours   <= btn_up ? bcd_inc(r_hours, 8'h23)   : bcd_dec(r_hours, 8'h23);
                    ST_SET_MINUTES: r_minutes <= btn_up ? bcd_inc(r_minutes, 8'h59) : bcd_dec(r_minutes, 8'h59);
                    ST_SET_SECONDS: r_seconds <= btn_up ? bcd_inc(r_seconds, 8'h59) : bcd_dec(r_seconds, 8'h59);
                    default:        ;
                endcase
            end

            if (!w_in_set || w_mode_press || !w_one_btn) begin
                r_rep      <= 32'd0;
                r_rep_fast <= 1'b0;
            end else if (w_press_step) begin
                r_rep      <= 32'd1;
                r_rep_fast <= 1'b0;
            end else if (w_rep_due) begin
                r_rep      <= 32'd1;
                r_rep_fast <= 1'b1;
            end else if (r_rep != 32'd0) begin
                r_rep <= r_rep + 32'd1;
            end

            if (w_next_state == ST_RUN) begin
                r_blink <= 1'b0;
                r_hold  <= 32'd0;
            end else if (w_step || (r_blink && (btn_up || btn_down))) begin
                r_blink <= 1'b1;
                r_hold  <= 32'd0;
            end else if (r_blink) begin
                if (r_hold == HOLD_CYCLES) begin
                    r_blink <= 1'b0;
                    r_hold  <= 32'd0;
                end else begin
                    r_hold <= r_hold + 32'd1;
                end
            end

            if (!w_in_set || w_any_btn || w_timeout) r_tmo <= 32'd0;
            else                                     r_tmo <= r_tmo + 32'd1;
        end
    end

    assign hours        = r_hours;
    assign minutes      = r_minutes;
    assign seconds      = r_seconds;
    assign currentState = r_state;
    assign activeBlink  = r_blink;

endmodule

// File: tb/tb_time_set_editor.sv
// Directed bench for time_set_editor with short timing parameters.
// Inputs change on falling edges; outputs are checked on falling edges.
module tb_time_set_editor;

    logic       CLK;
    logic       RST_N;
    logic       btn_mode, btn_up, btn_down;
    logic [7:0] hours, minutes, seconds;
    logic [1:0] currentState;
    logic       activeBlink;

    int tests_run    = 0;
    int tests_failed = 0;

    time_set_editor #(
        .CLK_HZ(10), .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .HOLD_CYCLES(5), .EDIT_TIMEOUT(40)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .currentState(currentState), .activeBlink(activeBlink)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1; @(negedge CLK); btn_mode = 1'b0;
    endtask

    task automatic pulse_up();
        btn_up = 1'b1; @(negedge CLK); btn_up = 1'b0;
    endtask

    task automatic pulse_down();
        btn_down = 1'b1; @(negedge CLK); btn_down = 1'b0;
    endtask

    initial begin
        int steps;
        RST_N = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        tick(2);
        check("rst_hours", hours, 8'h00);
        check("rst_minutes", minutes, 8'h00);
        check("rst_seconds", seconds, 8'h00);
        check("rst_state", currentState, 2'd0);
        check("rst_blink", activeBlink, 1'b0);

        // Mode cycling with frozen time.
        RST_N = 1'b1;
        pulse_mode();
        check("mode_1", currentState, 2'd1);
        tick(3);
        check("frozen_sec", seconds, 8'h00);
        pulse_mode();
        check("mode_2", currentState, 2'd2);
        tick(2);
        pulse_mode();
        check("mode_3", currentState, 2'd3);
        tick(2);
        pulse_mode();
        check("mode_0", currentState, 2'd0);
        tick(9);
        check("first_tick_early", seconds, 8'h00);
        tick(1);
        check("first_tick", seconds, 8'h01);

        // Decrement wrap on hours, then preload 23:59:58.
        pulse_mode();
        check("set_hours", currentState, 2'd1);
        pulse_down();
        check("hours_dec_wrap", hours, 8'h23);
        check("minutes_untouched", minutes, 8'h00);
        check("blink_on_step", activeBlink, 1'b1);
        pulse_mode();
        pulse_down();
        check("minutes_dec_wrap", minutes, 8'h59);
        pulse_mode();
        check("set_seconds", currentState, 2'd3);
        pulse_down(); tick(1);
        pulse_down(); tick(1);
        pulse_down();
        check("preload_sec", seconds, 8'h58);
        pulse_mode();
        check("back_to_run", currentState, 2'd0);
        check("blink_off_run", activeBlink, 1'b0);

        // Rollover.
        tick(9);
        check("roll_s58", seconds, 8'h58);
        tick(1);
        check("roll_s59", seconds, 8'h59);
        tick(9);
        check("roll_s59_hold", seconds, 8'h59);
        tick(1);
        check("roll_h", hours, 8'h00);
        check("roll_m", minutes, 8'h00);
        check("roll_s", seconds, 8'h00);

        // Auto-repeat in SET_MINUTES from 00.
        pulse_mode(); tick(1);
        pulse_mode();
        check("rep_state", currentState, 2'd2);
        btn_up = 1'b1;
        steps = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (i == 0 || i == 8 || i == 11 || i == 14 || i == 17) steps++;
            check($sformatf("rep_min_%0d", i), minutes, 32'(steps));
            check($sformatf("rep_blink_%0d", i), activeBlink, 1'b1);
        end
        check("rep_final", minutes, 8'h05);
        btn_up = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge CLK);
            check($sformatf("hold_blink_%0d", j), activeBlink, (j < 5) ? 1'b1 : 1'b0);
        end

        // BCD carry within the field: 09 -> 10.
        for (int i = 0; i < 4; i++) begin
            pulse_up(); tick(1);
        end
        check("min_09", minutes, 8'h09);
        pulse_up();
        check("min_bcd_10", minutes, 8'h10);
        tick(1);

        // Conflicts: up+down together, then mode+up together.
        btn_up = 1'b1; btn_down = 1'b1;
        tick(12);
        check("updown_nochange", minutes, 8'h10);
        btn_up = 1'b0; btn_down = 1'b0;
        tick(1);
        btn_mode = 1'b1; btn_up = 1'b1;
        @(negedge CLK);
        btn_mode = 1'b0;
        check("conf_state", currentState, 2'd3);
        check("conf_min", minutes, 8'h10);
        check("conf_sec", seconds, 8'h00);
        tick(11);
        check("conf_no_repeat", seconds, 8'h00);
        btn_up = 1'b0;
        tick(1);
        pulse_up();
        check("repress_step", seconds, 8'h01);

        // Edit timeout.
        tick(39);
        check("tmo_before", currentState, 2'd3);
        tick(1);
        check("tmo_run", currentState, 2'd0);

        // Asynchronous reset during auto-repeat.
        pulse_mode();
        btn_up = 1'b1;
        tick(10);
        check("pre_rst_hours", hours, 8'h02);
        check("pre_rst_state", currentState, 2'd1);
        check("pre_rst_blink", activeBlink, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        check("arst_hours", hours, 8'h00);
        check("arst_minutes", minutes, 8'h00);
        check("arst_seconds", seconds, 8'h00);
        check("arst_state", currentState, 2'd0);
        check("arst_blink", activeBlink, 1'b0);
        tick(1);
        RST_N = 1'b1;
        tick(2);
        check("post_rst_run_ignores_up", hours, 8'h00);
        btn_up = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
